mem_responder: RTL and testbench

Word-addressed memory target that answers the datapath's MAR/MDR memory port. It accepts read/write strobes from the control unit, with the address taken from MAR_Data and the write data from MDR_Data. It inserts a parameterised number of wait states, performs the access on an internal RAM array and returns read data on the line feeding MDR's memory input (MDataIN). Completion uses a four-phase done/strobe handshake, so a held strobe never causes a repeated access.

---
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory target behind the MAR/MDR port, with configurable wait states
// and a four-phase done/strobe handshake so a held strobe never repeats an access.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        done,
    output logic        busy,
    output logic        addr_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam bit              NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] WAIT_INIT = NO_WAIT ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 op_wr, op_wr_n;
    logic [31:0]          addr_q, addr_n;
    logic [DATA_W-1:0]    wdata_q, wdata_n;
    logic [DATA_W-1:0]    data_out_n;
    logic                 done_n, busy_n, addr_err_n;
    logic                 mem_we_c;
    logic                 oor_c;
    logic [ADDR_BITS-1:0] idx_c;

    // No reset on the array: contents persist across clr.
    logic [DATA_W-1:0] mem [DEPTH];

    assign idx_c = addr_q[ADDR_BITS-1:0];
    assign oor_c = |addr_q[31:ADDR_BITS];

    // State and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op_wr    <= op_wr_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            data_out <= data_out_n;
            done     <= done_n;
            busy     <= busy_n;
            addr_err <= addr_err_n;
        end
    end

    // Next-state, transaction latch and output computation
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        op_wr_n    = op_wr;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        data_out_n = data_out;
        addr_err_n = addr_err;
        mem_we_c   = 1'b0;

        case (state)
            S_IDLE: begin
                // Simultaneous read and write is treated as no request.
                if (read ^ write) begin
                    op_wr_n = write;
                    addr_n  = address;
                    wdata_n = data_in;
                    if (NO_WAIT) begin
                        state_n = S_ACCESS;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_ACCESS;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_ACCESS: begin
                state_n    = S_DONE;
                addr_err_n = oor_c;
                if (op_wr) begin
                    mem_we_c = ~oor_c;
                end else begin
                    data_out_n = oor_c ? '0 : mem[idx_c];
                end
            end
            S_DONE: begin
                if (!read && !write) begin
                    state_n    = S_IDLE;
                    addr_err_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        done_n = (state_n == S_DONE);
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a transaction-level model checks the WAIT_CYCLES=2
// instance every cycle; a second instance with WAIT_CYCLES=0 is checked with literals.
module tb_mem_responder;

    localparam int unsigned AB = 9;
    localparam int unsigned W  = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        read, write;
    logic [31:0] address, data_in;
    logic [31:0] data_out;
    logic        done, busy, addr_err;

    logic        read0, write0;
    logic [31:0] address0, data_in0;
    logic [31:0] data_out0;
    logic        done0, busy0, addr_err0;

    int total = 0;
    int bad   = 0;

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
        .clk(clk), .clr(clr), .read(read), .write(write),
        .address(address), .data_in(data_in), .data_out(data_out),
        .done(done), .busy(busy), .addr_err(addr_err)
    );

    mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .clr(clr), .read(read0), .write(write0),
        .address(address0), .data_in(data_in0), .data_out(data_out0),
        .done(done0), .busy(busy0), .addr_err(addr_err0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: accept on a lone strobe, complete W+1 cycles later,
    // hold done until both strobes are seen low.
    logic [31:0] mmem [int];
    bit          m_busy, m_done, m_err, m_wr, m_oor;
    logic [31:0] m_dout = '0;
    logic [31:0] m_addr, m_data;
    int          m_idx;
    int          cyc   = 0;
    int          t_acc = 0;

    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_busy = 0; m_done = 0; m_err = 0; m_dout = '0;
        end else if (!m_busy) begin
            if (read ^ write) begin
                m_busy = 1; m_wr = write; m_addr = address; m_data = data_in;
                t_acc  = cyc + W + 1;
            end
        end else if (!m_done) begin
            if (cyc == t_acc) begin
                m_oor = (m_addr >> AB) != 0;
                m_idx = int'(m_addr % (32'd1 << AB));
                if (m_wr) begin
                    if (!m_oor) mmem[m_idx] = m_data;
                end else if (m_oor) begin
                    m_dout = '0;
                end else if (mmem.exists(m_idx)) begin
                    m_dout = mmem[m_idx];
                end
                m_err  = m_oor;
                m_done = 1;
            end
        end else if (!read && !write) begin
            m_busy = 0; m_done = 0; m_err = 0;
        end
        #1;
        if (!clr) begin
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_addr_err", 32'(addr_err), 32'(m_err));
            chk("m_data_out", data_out, m_dout);
        end
    end

    task automatic req(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input int hold,
                       input bit chk_d, input logic [31:0] exp_d, input bit exp_e);
        int lat;
        @(negedge clk);
        if (sel) begin
            read0 = rd; write0 = wr; address0 = a; data_in0 = d;
        end else begin
            read = rd; write = wr; address = a; data_in = d;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!(sel ? done0 : done) && lat < 20);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err_at_done", 32'(sel ? addr_err0 : addr_err), 32'(exp_e));
        if (chk_d) chk("dout_at_done", sel ? data_out0 : data_out, exp_d);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("done_held", 32'(sel ? done0 : done), 32'd1);
        end
        @(negedge clk);
        if (sel) begin read0 = 0; write0 = 0; end
        else begin read = 0; write = 0; end
        @(posedge clk); #1;
        chk("done_clear", 32'(sel ? done0 : done), 32'd0);
        chk("busy_clear", 32'(sel ? busy0 : busy), 32'd0);
        chk("err_clear", 32'(sel ? addr_err0 : addr_err), 32'd0);
    endtask

    initial begin
        clr = 1; read = 0; write = 0; address = '0; data_in = '0;
        read0 = 0; write0 = 0; address0 = '0; data_in0 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        @(negedge clk) clr = 0;

        req(0, 0, 1, 32'h5,        32'hDEADBEEF, 3, 0,  0, 32'h0,        0);
        req(0, 1, 0, 32'h5,        32'h0,        3, 10, 1, 32'hDEADBEEF, 0);
        req(0, 0, 1, 32'h0,        32'h11111111, 3, 0,  0, 32'h0,        0);
        req(0, 0, 1, 32'h200,      32'h12345678, 3, 0,  0, 32'h0,        1);
        req(0, 1, 0, 32'h0,        32'h0,        3, 0,  1, 32'h11111111, 0);
        req(0, 1, 0, 32'h200,      32'h0,        3, 0,  1, 32'h0,        1);
        req(0, 1, 0, 32'h1FF,      32'h0,        3, 0,  0, 32'h0,        0);
        req(0, 0, 1, 32'h1FF,      32'hFEEDC0DE, 3, 0,  0, 32'h0,        0);
        req(0, 1, 0, 32'h1FF,      32'h0,        3, 0,  1, 32'hFEEDC0DE, 0);
        req(0, 1, 0, 32'h80000005, 32'h0,        3, 0,  1, 32'h0,        1);

        // Conflicting strobes are ignored
        req(0, 1, 0, 32'h5, 32'h0, 3, 0, 1, 32'hDEADBEEF, 0);
        @(negedge clk);
        read = 1; write = 1; address = 32'h0; data_in = 32'hFFFFFFFF;
        repeat (5) begin
            @(posedge clk); #1;
            chk("conflict_busy", 32'(busy), 32'd0);
            chk("conflict_done", 32'(done), 32'd0);
        end
        @(negedge clk) begin read = 0; write = 0; end
        req(0, 1, 0, 32'h0, 32'h0, 3, 0, 1, 32'h11111111, 0);

        // Reset during WAIT discards the pending write
        req(0, 0, 1, 32'h10, 32'h0BADF00D, 3, 0, 0, 32'h0, 0);
        req(0, 1, 0, 32'h5, 32'h0, 3, 0, 1, 32'hDEADBEEF, 0);
        @(negedge clk);
        write = 1; address = 32'h10; data_in = 32'hA5A5A5A5;
        @(posedge clk);
        @(posedge clk);
        #1; chk("wait_busy", 32'(busy), 32'd1);
        #2 clr = 1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_addr_err", 32'(addr_err), 32'd0);
        @(negedge clk) write = 0;
        @(posedge clk);
        @(negedge clk) clr = 0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        req(0, 1, 0, 32'h10, 32'h0, 3, 0, 1, 32'h0BADF00D, 0);

        // Zero wait states
        req(1, 0, 1, 32'h77,  32'hCAFEF00D, 1, 0, 0, 32'h0,        0);
        req(1, 1, 0, 32'h77,  32'h0,        1, 2, 1, 32'hCAFEF00D, 0);
        req(1, 1, 0, 32'h400, 32'h0,        1, 0, 1, 32'h0,        1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
